ifu_iccm_dma_arb: RTL

- Arbitrates the single ICCM port between the fetch pipe (F1 ICCM fetches) and DMA read/write requests.
- Queues DMA requests and issues one whenever the fetch control reports the port free.
- After a bounded wait it forces a fetch-pipe stall so DMA cannot starve.
- Sits between the DMA slave and the ICCM macro, beside fetch control.

---
 rtl/ifu_iccm_dma_arb_pkg.sv | 21 ++
 rtl/ifu_iccm_dma_arb_if.sv | 22 ++
 rtl/ifu_iccm_dma_fifo.sv | 70 +++++++
 rtl/ifu_iccm_dma_arb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ifu_iccm_dma_arb_pkg.sv
// Shared types for the ICCM port arbiter between fetch and DMA.
package ifu_iccm_arb_pkg;

    localparam int ICCM_ADDR_W = 16;
    localparam int ICCM_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        FORCE = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic                   write;
        logic [ICCM_ADDR_W-1:0] addr;
        logic [ICCM_DATA_W-1:0] wdata;
    } dma_iccm_req_t;

    localparam int REQ_W = $bits(dma_iccm_req_t);

endpackage

// File: rtl/ifu_iccm_dma_arb_if.sv
// DMA-side request/response bundle; the DMA slave is master, the arbiter is slave.
interface ifu_iccm_dma_arb_if #(
    parameter int ADDR_W = 16
) ();
    logic              dma_req_valid;
    logic              dma_req_ready;
    logic              dma_req_write;
    logic [ADDR_W-1:0] dma_req_addr;
    logic [63:0]       dma_req_wdata;
    logic              dma_rsp_valid;
    logic [63:0]       dma_rsp_rdata;

    modport master (
        output dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata,
        input  dma_req_ready, dma_rsp_valid, dma_rsp_rdata
    );

    modport slave (
        input  dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata,
        output dma_req_ready, dma_rsp_valid, dma_rsp_rdata
    );
endinterface

// File: rtl/ifu_iccm_dma_fifo.sv
// Small power-of-two FIFO holding pending DMA requests; no bypass path.
module ifu_iccm_dma_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 81,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == CW'(0));
    assign count  = count_q;
    assign rdata  = mem_q[rd_ptr_q];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ifu_iccm_dma_arb.sv
// ICCM port arbiter: queues DMA requests, issues them when fetch frees the port,
// and forces a fetch stall after a bounded wait so DMA cannot starve.
module ifu_iccm_dma_arb
    import ifu_iccm_arb_pkg::*;
#(
    parameter int ADDR_W     = ICCM_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 15,
    parameter int RD_LAT     = 2,
    localparam int CNT_W     = $clog2(STARVE_MAX + 1),
    localparam int QCNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    ifu_iccm_dma_arb_if.slave dma,
    input  logic              ifc_dma_access_ok,
    input  logic              exu_flush_final,
    output logic              dma_iccm_stall_any,
    output logic              iccm_dma_en,
    output logic              iccm_dma_wren,
    output logic [ADDR_W-1:0] iccm_dma_addr,
    output logic [63:0]       iccm_dma_wdata,
    input  logic [63:0]       iccm_rd_data,
    output logic              dma_starve_pulse
);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_s;
    logic                stall_q, stall_d;
    logic                pulse_q, pulse_d;
    logic [RD_LAT-1:0]   rsp_vld_q, rsp_vld_d;
    logic [RD_LAT-1:0]   rsp_rd_q, rsp_rd_d;

    dma_iccm_req_t       enq_req_s, head_req_s;
    logic [REQ_W-1:0]    head_raw_s;
    logic                full_s, empty_s, enq_s, issue_s, drain_empty_s;
    logic [QCNT_W-1:0]   qcount_s;
    logic                flush_unused_s;

    // A flush belongs to the fetch side only; queued and issued DMA proceed regardless.
    assign flush_unused_s = exu_flush_final;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_W'(STARVE_MAX)) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign enq_req_s = '{write: dma.dma_req_write, addr: dma.dma_req_addr, wdata: dma.dma_req_wdata};
    assign head_req_s = dma_iccm_req_t'(head_raw_s);

    assign dma.dma_req_ready = ~full_s;
    assign enq_s             = dma.dma_req_valid & ~full_s;
    assign issue_s           = ~empty_s & ifc_dma_access_ok;
    assign drain_empty_s     = (qcount_s == QCNT_W'(1)) & issue_s & ~enq_s;
    assign cnt_inc_s         = sat_inc(cnt_q);

    ifu_iccm_dma_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (enq_s),
        .pop   (issue_s),
        .wdata (enq_req_s),
        .rdata (head_raw_s),
        .full  (full_s),
        .empty (empty_s),
        .count (qcount_s)
    );

    assign iccm_dma_en    = issue_s;
    assign iccm_dma_wren  = issue_s & head_req_s.write;
    assign iccm_dma_addr  = head_req_s.addr;
    assign iccm_dma_wdata = head_req_s.wdata;

    // Starvation FSM: the wait count reaches STARVE_MAX on the last tolerated idle cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enq_s & ~issue_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (drain_empty_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (issue_s) begin
                    cnt_d = '0;
                end else if (cnt_inc_s == CNT_W'(STARVE_MAX)) begin
                    state_d = FORCE;
                    cnt_d   = cnt_inc_s;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            FORCE: begin
                if (drain_empty_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = FORCE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        stall_d = (state_d == FORCE);
    end

    // Response pipe: each issue surfaces RD_LAT cycles later, tagged read or write.
    always_comb begin
        rsp_vld_d    = '0;
        rsp_rd_d     = '0;
        rsp_vld_d[0] = issue_s;
        rsp_rd_d[0]  = issue_s & ~head_req_s.write;
        for (int i = 1; i < RD_LAT; i++) begin
            rsp_vld_d[i] = rsp_vld_q[i-1];
            rsp_rd_d[i]  = rsp_rd_q[i-1];
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            pulse_q   <= 1'b0;
            rsp_vld_q <= '0;
            rsp_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            pulse_q   <= pulse_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_rd_q  <= rsp_rd_d;
        end
    end

    assign dma_iccm_stall_any = stall_q;
    assign dma_starve_pulse   = pulse_q;
    assign dma.dma_rsp_valid  = rsp_vld_q[RD_LAT-1];
    assign dma.dma_rsp_rdata  = rsp_rd_q[RD_LAT-1] ? iccm_rd_data : 64'd0;

endmodule
